// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state encoding, opcodes and control field encodings shared by the controller
package multicycle_control_pkg;
  localparam int MEM_TIMEOUT_DEF = 255;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_FAULT
  } state_e;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields, memory handshake and datapath control lines
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       fault;
  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, fault
  );
  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, fault
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// alu_decoder: maps op/funct3/funct7b5 to an ALU operation and flags unsupported funct3
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);
  assign alu_ctrl_o = funct3_i == 3'b000 ? ((op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD) :
                      funct3_i == 3'b111 ? ALU_AND :
                      funct3_i == 3'b110 ? ALU_OR  :
                      funct3_i == 3'b010 ? ALU_SLT : ALU_ADD;
  assign illegal_o = !(funct3_i inside {3'b000, 3'b111, 3'b110, 3'b010});
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RISC-V style main FSM with memory wait timeout and sticky fault
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dec_alu;
  logic          dec_illegal, waiting, timeout;
  alu_decoder u_dec (
    .op_i       (bus.op),
    .funct3_i   (bus.funct3),
    .funct7b5_i (bus.funct7b5),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );
  // non-wait states hold the counter at zero, so entry to a wait state always starts fresh
  assign waiting = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  assign cnt_d   = (waiting && !bus.mem_ready) ? cnt_q + 1'b1 : '0;
  assign timeout = waiting && !bus.mem_ready && cnt_q == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    state_q <= rst ? S_FETCH : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ALUControl = ALU_ADD;
    bus.ImmSrc     = IMM_I;
    bus.fault      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.IRWrite   = 1'b1;
            bus.PCWrite   = 1'b1;
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ResultSrc = RES_ALU;
            state_d       = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_IMM;
          bus.ImmSrc  = bus.op == OP_JAL ? IMM_J : IMM_B;
          state_d = bus.op inside {OP_LW, OP_SW} ? S_MEMADR :
                    bus.op == OP_R   ? S_EXECR :
                    bus.op == OP_I   ? S_EXECI :
                    bus.op == OP_BEQ ? S_BEQ   :
                    bus.op == OP_JAL ? S_JAL   : S_FAULT;
        end
        S_MEMADR: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_IMM;
          bus.ImmSrc  = bus.op == OP_SW ? IMM_S : IMM_I;
          state_d     = bus.op == OP_SW ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.AdrSrc  = 1'b1;
          state_d     = bus.mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          bus.ResultSrc = RES_RDATA;
          bus.RegWrite  = 1'b1;
          state_d       = S_FETCH;
        end
        S_MEMWRITE: begin
          bus.mem_req  = 1'b1;
          bus.AdrSrc   = 1'b1;
          bus.MemWrite = 1'b1;
          state_d      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_EXECR, S_EXECI: begin
          bus.ALUSrcA    = SRCA_RS1;
          bus.ALUSrcB    = state_q == S_EXECI ? SRCB_IMM : SRCB_RS2;
          bus.ALUControl = dec_alu;
          state_d        = dec_illegal ? S_FAULT : S_ALUWB;
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          state_d      = S_FETCH;
        end
        S_BEQ: begin
          bus.ALUSrcA    = SRCA_RS1;
          bus.ALUControl = ALU_SUB;
          bus.PCWrite    = bus.Zero;
          state_d        = S_FETCH;
        end
        S_JAL: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_FOUR;
          bus.PCWrite = 1'b1;
          state_d     = S_ALUWB;
        end
        S_FAULT: bus.fault = 1'b1;
        default: state_d = S_FAULT;
      endcase
      if (timeout) state_d = S_FAULT;
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven instruction sequences plus hand-written fault, timeout and reset cases
module tb_multicycle_control;
  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    logic [18:0] exp;
  } vec_t;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  logic [18:0] E_Z, E_FW, E_FG, E_DB, E_DJ, E_MAL, E_MAS, E_MR, E_MWB, E_MW, E_AWB, E_JAL, E_FLT;
  multicycle_control_if bus();
  multicycle_control #(.MEM_TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // strobes = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite}
  function automatic logic [18:0] pk(input logic [5:0] strobes, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] ac, input logic [2:0] is, input logic f);
    return {strobes, rs, sa, sb, ac, is, f};
  endfunction
  function automatic logic [18:0] xr(input logic [2:0] ac);
    return pk(6'b000000, 2'b00, 2'b10, 2'b00, ac, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] xi(input logic [2:0] ac);
    return pk(6'b000000, 2'b00, 2'b10, 2'b01, ac, 3'b000, 1'b0);
  endfunction
  function automatic logic [18:0] bq(input logic z);
    return pk({4'b0000, z, 1'b0}, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1'b0);
  endfunction
  task automatic add(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic rdy, input logic [18:0] e);
    tbl.push_back('{n, o, f3, f7, z, rdy, e});
  endtask
  task automatic step(input logic r, input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input logic [18:0] e, input bit chk = 1'b1);
    logic [18:0] got;
    @(negedge clk);
    rst = r;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.Zero = z;
    bus.mem_ready = rdy;
    #1;
    got = {bus.mem_req, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite,
           bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.fault};
    if (chk) begin
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", n, got, e);
      end
    end
  endtask
  task automatic prog3(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [18:0] e3);
    add({n, "_fetch"}, o, 3'b000, 1'b0, 1'b0, 1'b1, E_FG);
    add({n, "_dec"}, o, f3, f7, 1'b0, 1'b0, E_DB);
    add({n, "_exec"}, o, f3, f7, z, 1'b0, e3);
  endtask
  initial begin
    E_Z   = pk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_FW  = pk(6'b100000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_FG  = pk(6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0);
    E_DB  = pk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 1'b0);
    E_DJ  = pk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 1'b0);
    E_MAL = pk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0);
    E_MAS = pk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 1'b0);
    E_MR  = pk(6'b110000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_MWB = pk(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_MW  = pk(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_AWB = pk(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0);
    E_JAL = pk(6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0);
    E_FLT = pk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1);
    prog3("lw", LW, 3'b010, 1'b0, 1'b0, E_MAL);
    add("lw_rd", LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MR);
    add("lw_wb", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MWB);
    add("sw_fw1", LW, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    add("sw_fw2", LW, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    prog3("sw", SW, 3'b010, 1'b0, 1'b0, E_MAS);
    for (int i = 0; i < 3; i++) add("sw_wait", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_MW);
    add("sw_done", SW, 3'b010, 1'b0, 1'b0, 1'b1, E_MW);
    prog3("sub", RT, 3'b000, 1'b1, 1'b0, xr(3'b001));
    add("sub_wb", RT, 3'b000, 1'b1, 1'b0, 1'b0, E_AWB);
    prog3("add", RT, 3'b000, 1'b0, 1'b0, xr(3'b000));
    add("add_wb", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("slt", RT, 3'b010, 1'b0, 1'b0, xr(3'b101));
    add("slt_wb", RT, 3'b010, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("and", RT, 3'b111, 1'b0, 1'b0, xr(3'b010));
    add("and_wb", RT, 3'b111, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("or", RT, 3'b110, 1'b0, 1'b0, xr(3'b011));
    add("or_wb", RT, 3'b110, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("addi", IT, 3'b000, 1'b1, 1'b0, xi(3'b000));
    add("addi_wb", IT, 3'b000, 1'b1, 1'b0, 1'b0, E_AWB);
    prog3("ori", IT, 3'b110, 1'b0, 1'b0, xi(3'b011));
    add("ori_wb", IT, 3'b110, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("slti", IT, 3'b010, 1'b0, 1'b0, xi(3'b101));
    add("slti_wb", IT, 3'b010, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("beq_t", BQ, 3'b000, 1'b0, 1'b1, bq(1'b1));
    prog3("beq_nt", BQ, 3'b000, 1'b0, 1'b0, bq(1'b0));
    add("jal_fetch", JL, 3'b000, 1'b0, 1'b0, 1'b1, E_FG);
    add("jal_dec", JL, 3'b000, 1'b0, 1'b0, 1'b0, E_DJ);
    add("jal", JL, 3'b000, 1'b0, 1'b0, 1'b0, E_JAL);
    add("jal_wb", JL, 3'b000, 1'b0, 1'b0, 1'b0, E_AWB);
    prog3("lw2", LW, 3'b010, 1'b0, 1'b0, E_MAL);
    for (int i = 0; i < 3; i++) add("lw2_wait", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MR);
    add("lw2_rd", LW, 3'b010, 1'b0, 1'b0, 1'b1, E_MR);
    add("lw2_wb", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MWB);
    add("end_fetch", LW, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    step(1'b1, "rst_a", LW, 3'b000, 1'b0, 1'b0, 1'b1, E_Z);
    step(1'b1, "rst_b", LW, 3'b000, 1'b0, 1'b0, 1'b1, E_Z);
    foreach (tbl[i]) step(1'b0, tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy, tbl[i].exp);
    // illegal opcode: fault the cycle after DECODE, sticky until reset
    step(1'b1, "ill_rst0", BAD, 3'b000, 1'b0, 1'b0, 1'b1, E_Z);
    step(1'b0, "ill_fetch", BAD, 3'b000, 1'b0, 1'b0, 1'b1, E_FG);
    step(1'b0, "ill_dec", BAD, 3'b000, 1'b0, 1'b0, 1'b0, E_DB);
    step(1'b0, "ill_fault", BAD, 3'b000, 1'b0, 1'b0, 1'b0, E_FLT);
    for (int i = 0; i < 100; i++)
      step(1'b0, "ill_sticky", BAD, 3'b000, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), E_FLT);
    step(1'b1, "ill_rst", BAD, 3'b000, 1'b0, 1'b0, 1'b1, E_Z);
    step(1'b0, "ill_after", BAD, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    step(1'b0, "f3_fetch", RT, 3'b001, 1'b0, 1'b0, 1'b1, E_FG);
    step(1'b0, "f3_dec", RT, 3'b001, 1'b0, 1'b0, 1'b0, E_DB);
    step(1'b0, "f3_exec", RT, 3'b001, 1'b0, 1'b0, 1'b0, E_Z, 1'b0);
    step(1'b0, "f3_fault", RT, 3'b001, 1'b0, 1'b0, 1'b0, E_FLT);
    // fetch timeout after four low-ready cycles, then the same wait rescued by ready in the fourth
    step(1'b1, "to_rst", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_Z);
    for (int i = 0; i < 4; i++) step(1'b0, "to_wait", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    step(1'b0, "to_fault", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_FLT);
    step(1'b1, "to_rst2", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_Z);
    for (int i = 0; i < 3; i++) step(1'b0, "ok_wait", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_FW);
    step(1'b0, "ok_go", RT, 3'b000, 1'b0, 1'b0, 1'b1, E_FG);
    step(1'b0, "ok_dec", RT, 3'b000, 1'b0, 1'b0, 1'b0, E_DB);
    step(1'b1, "rd_rst", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_Z);
    step(1'b0, "rd_fetch", LW, 3'b010, 1'b0, 1'b0, 1'b1, E_FG);
    step(1'b0, "rd_dec", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_DB);
    step(1'b0, "rd_adr", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MAL);
    for (int i = 0; i < 4; i++) step(1'b0, "rd_wait", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_MR);
    step(1'b0, "rd_fault", LW, 3'b010, 1'b0, 1'b0, 1'b0, E_FLT);
    // reset in the middle of a store returns to FETCH
    step(1'b1, "mid_rst0", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_Z);
    step(1'b0, "mid_fetch", SW, 3'b010, 1'b0, 1'b0, 1'b1, E_FG);
    step(1'b0, "mid_dec", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_DB);
    step(1'b0, "mid_adr", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_MAS);
    step(1'b0, "mid_wr", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_MW);
    step(1'b1, "mid_rst", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_Z);
    step(1'b0, "mid_after", SW, 3'b010, 1'b0, 1'b0, 1'b0, E_FW);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
